// File: rtl/idct_pkg.sv
// Shared types and width helpers for the sequential 8-point 1-D IDCT.
// Optional build macro IDCT_ROUND_EN selects round-half-up terms in idct_mac_lane.
package idct_pkg;

    localparam int IDCT_N         = 8;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_FRAC_BITS  = 16;
    localparam int DEF_GUARD_BITS = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic int acc_width(input int dw, input int gb);
        return dw + gb;
    endfunction

    function automatic int prod_width(input int dw);
        return 2 * dw;
    endfunction

    localparam int DEF_ACC_WIDTH  = acc_width(DEF_DATA_WIDTH, DEF_GUARD_BITS);
    localparam int DEF_PROD_WIDTH = prod_width(DEF_DATA_WIDTH);

endpackage

// File: rtl/idct_mac_lane.sv
// One IDCT output lane: signed multiply, scale, accumulate, saturate.
// Build macro IDCT_ROUND_EN: round-half-up scaling instead of floor truncation.
module idct_mac_lane
    import idct_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int FRAC_BITS  = DEF_FRAC_BITS,
    parameter int GUARD_BITS = DEF_GUARD_BITS
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  clear_i,
    input  logic                  enable_i,
    input  logic [DATA_WIDTH-1:0] coeff_i,
    input  logic [DATA_WIDTH-1:0] sample_i,
    output logic [DATA_WIDTH-1:0] sat_o
);

    localparam int AW = acc_width(DATA_WIDTH, GUARD_BITS);
    localparam int PW = prod_width(DATA_WIDTH);
    localparam logic [PW-1:0] HALF_LSB = PW'(1) << (FRAC_BITS - 1);

    logic signed [PW-1:0] coeff_ext, sample_ext;
    logic signed [PW-1:0] prod, prod_adj, shifted;
    logic signed [AW-1:0] term, acc_q, acc_d;
    logic        [AW:0]   sum;
    logic                 unused_hi;

    always_comb begin
        coeff_ext  = PW'($signed(coeff_i));
        sample_ext = PW'($signed(sample_i));
        prod       = coeff_ext * sample_ext;
`ifdef IDCT_ROUND_EN
        prod_adj   = prod + $signed(HALF_LSB);
`else
        prod_adj   = prod;
`endif
        shifted    = prod_adj >>> FRAC_BITS;
        term       = shifted[AW-1:0];
        // One extra bit so the final add cannot wrap before the clamp.
        sum        = {acc_q[AW-1], acc_q} + {term[AW-1], term};

        if ((sum[AW:DATA_WIDTH-1] == '0) || (sum[AW:DATA_WIDTH-1] == '1)) begin
            sat_o = sum[DATA_WIDTH-1:0];
        end else if (sum[AW]) begin
            sat_o = {1'b1, {(DATA_WIDTH-1){1'b0}}};
        end else begin
            sat_o = {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end

        acc_d = acc_q;
        if (clear_i) begin
            acc_d = '0;
        end else if (enable_i) begin
            acc_d = sum[AW-1:0];
        end
    end

    assign unused_hi = ^shifted[PW-1:AW];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/idct_1d_seq.sv
// Time-multiplexed 8-point 1-D IDCT: FSM, k counter, X capture, column mux, handshakes.
// Build macro IDCT_ROUND_EN (in idct_mac_lane) switches term scaling to round-half-up.
module idct_1d_seq
    import idct_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DATA_DEPTH = IDCT_N,
    parameter int FRAC_BITS  = DEF_FRAC_BITS,
    parameter int GUARD_BITS = DEF_GUARD_BITS
) (
    input  logic                                   clk,
    input  logic                                   reset_n,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic [DATA_WIDTH*DATA_DEPTH-1:0]       data_in,
    input  logic [DATA_WIDTH*DATA_DEPTH*DATA_DEPTH-1:0] coeff_matrix,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [DATA_WIDTH*DATA_DEPTH-1:0]       data_out
);

    localparam int N  = DATA_DEPTH;
    localparam int KW = $clog2(N);
    localparam logic [KW-1:0] K_LAST = KW'(N - 1);

    state_e                  state_q, state_d;
    logic [KW-1:0]           k_q, k_d;
    logic [DATA_WIDTH-1:0]   x_q [N];
    logic [DATA_WIDTH-1:0]   x_d [N];
    logic [DATA_WIDTH*N-1:0] dout_q, dout_d;
    logic                    accept, lane_en;
    logic [DATA_WIDTH-1:0]   x_sel;
    logic [DATA_WIDTH-1:0]   lane_coeff [N];
    logic [DATA_WIDTH-1:0]   lane_sat   [N];

    assign x_sel = x_q[k_q];

    // Lane n consumes column n of row k, so all lanes share X[k] each cycle.
    for (genvar n = 0; n < N; n++) begin : g_lane
        assign lane_coeff[n] = coeff_matrix[(int'(k_q) * N + n) * DATA_WIDTH +: DATA_WIDTH];

        idct_mac_lane #(
            .DATA_WIDTH (DATA_WIDTH),
            .FRAC_BITS  (FRAC_BITS),
            .GUARD_BITS (GUARD_BITS)
        ) u_lane (
            .clk      (clk),
            .reset_n  (reset_n),
            .clear_i  (accept),
            .enable_i (lane_en),
            .coeff_i  (lane_coeff[n]),
            .sample_i (x_sel),
            .sat_o    (lane_sat[n])
        );
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        dout_d  = dout_q;
        accept  = 1'b0;
        lane_en = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            x_d[i] = x_q[i];
        end

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    accept  = 1'b1;
                    k_d     = '0;
                    state_d = MAC;
                    for (int unsigned i = 0; i < N; i++) begin
                        x_d[i] = data_in[i*DATA_WIDTH +: DATA_WIDTH];
                    end
                end
            end
            MAC: begin
                lane_en = 1'b1;
                k_d     = k_q + 1'b1;
                if (k_q == K_LAST) begin
                    state_d = DONE;
                    for (int unsigned i = 0; i < N; i++) begin
                        dout_d[i*DATA_WIDTH +: DATA_WIDTH] = lane_sat[i];
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            k_q     <= '0;
            dout_q  <= '0;
            for (int unsigned i = 0; i < N; i++) begin
                x_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            dout_q  <= dout_d;
            for (int unsigned i = 0; i < N; i++) begin
                x_q[i] <= x_d[i];
            end
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign data_out  = dout_q;

endmodule

// File: tb/tb_idct_1d_seq.sv
// Directed, table-driven bench for idct_1d_seq; expectations follow IDCT_ROUND_EN.
module tb_idct_1d_seq;

    localparam int DW = 32;
    localparam int N  = 8;
    localparam int NV = 9;

    logic                clk = 1'b0;
    logic                reset_n;
    logic                in_valid;
    logic                in_ready;
    logic [DW*N-1:0]     data_in;
    logic [DW*N*N-1:0]   coeff_matrix;
    logic                out_valid;
    logic                out_ready;
    logic [DW*N-1:0]     data_out;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [DW*N-1:0]   din;
        logic [DW*N*N-1:0] cm;
        logic [DW*N-1:0]   exp;
    } vec_t;

    vec_t vt [NV];

    idct_1d_seq #(
        .DATA_WIDTH (32),
        .DATA_DEPTH (8),
        .FRAC_BITS  (16),
        .GUARD_BITS (4)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .data_in      (data_in),
        .coeff_matrix (coeff_matrix),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .data_out     (data_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_lanes(input string tag, input logic [DW*N-1:0] exp);
        for (int n = 0; n < N; n++) begin
            chk($sformatf("%s_x%0d", tag, n), data_out[n*DW +: DW], exp[n*DW +: DW]);
        end
    endtask

    task automatic send(input int idx);
        int t;
        @(negedge clk);
        data_in      = vt[idx].din;
        coeff_matrix = vt[idx].cm;
        in_valid     = 1'b1;
        t = 0;
        while (!in_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk($sformatf("v%0d_in_ready", idx), 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!out_valid && lat < 20);
    endtask

    task automatic handshake(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        chk({tag, "_ovalid_drop"}, 32'(out_valid), 32'd0);
        chk({tag, "_iready_back"}, 32'(in_ready), 32'd1);
    endtask

    task automatic run(input int idx);
        int lat;
        send(idx);
        wait_out(lat);
        chk($sformatf("v%0d_latency", idx), 32'(lat), 32'd8);
        chk($sformatf("v%0d_busy_iready", idx), 32'(in_ready), 32'd0);
        check_lanes($sformatf("v%0d", idx), vt[idx].exp);
        handshake($sformatf("v%0d", idx));
    endtask

    initial begin
        int lat;

        for (int i = 0; i < NV; i++) begin
            vt[i].din = '0;
            vt[i].cm  = '0;
            vt[i].exp = '0;
        end
        for (int n = 0; n < N; n++) begin
            // 0: DC only
            vt[0].cm[n*DW +: DW]  = 32'h0000_5A82;
            vt[0].exp[n*DW +: DW] = 32'h0002_D410;
            // 1: identity
            vt[1].cm[(n*N + n)*DW +: DW] = 32'h0001_0000;
            vt[1].din[n*DW +: DW]        = 32'(n + 1) << 16;
            vt[1].exp[n*DW +: DW]        = 32'(n + 1) << 16;
            // 2/3: positive and negative saturation
            vt[2].din[n*DW +: DW] = 32'h7FFF_0000;
            vt[2].exp[n*DW +: DW] = 32'h7FFF_FFFF;
            vt[3].din[n*DW +: DW] = 32'h8000_0000;
            vt[3].exp[n*DW +: DW] = 32'h8000_0000;
            // 7: accumulate 0+1+..+7 without clamping
            vt[7].din[n*DW +: DW] = 32'(n) << 16;
            vt[7].exp[n*DW +: DW] = 32'h001C_0000;
            // 8: negative coefficient
            vt[8].cm[n*DW +: DW]  = 32'hFFFF_0000;
            vt[8].exp[n*DW +: DW] = 32'hFFFD_0000;
            for (int k = 0; k < N; k++) begin
                vt[2].cm[(k*N + n)*DW +: DW] = 32'h0001_0000;
                vt[3].cm[(k*N + n)*DW +: DW] = 32'h0001_0000;
                vt[7].cm[(k*N + n)*DW +: DW] = 32'h0001_0000;
            end
        end
        vt[0].din[0 +: DW] = 32'h0008_0000;
        vt[8].din[0 +: DW] = 32'h0003_0000;
        // 4/5: half-LSB products, positive and negative
        vt[4].cm[0 +: DW]  = 32'h0000_0001;
        vt[4].din[0 +: DW] = 32'h0000_8000;
        vt[5].cm[0 +: DW]  = 32'h0000_0001;
        vt[5].din[0 +: DW] = 32'hFFFF_8000;
`ifdef IDCT_ROUND_EN
        vt[4].exp[0 +: DW] = 32'h0000_0001;
        vt[5].exp[0 +: DW] = 32'h0000_0000;
`else
        vt[4].exp[0 +: DW] = 32'h0000_0000;
        vt[5].exp[0 +: DW] = 32'hFFFF_FFFF;
`endif
        // 6: single asymmetric entry C[1][5] = 2.0, X[1] = 1.5
        vt[6].cm[(1*N + 5)*DW +: DW] = 32'h0002_0000;
        vt[6].din[1*DW +: DW]        = 32'h0001_8000;
        vt[6].exp[5*DW +: DW]        = 32'h0003_0000;

        reset_n      = 1'b0;
        in_valid     = 1'b0;
        out_ready    = 1'b0;
        data_in      = '0;
        coeff_matrix = '0;
        #12;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        check_lanes("rst", '0);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            run(i);
        end

        // Back-pressure: hold DONE for 5 cycles with a second vector pending.
        send(7);
        wait_out(lat);
        chk("bp_latency", 32'(lat), 32'd8);
        data_in      = vt[6].din;
        coeff_matrix = vt[6].cm;
        in_valid     = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            chk($sformatf("bp_hold%0d_ovalid", c), 32'(out_valid), 32'd1);
            chk($sformatf("bp_hold%0d_iready", c), 32'(in_ready), 32'd0);
            check_lanes($sformatf("bp_hold%0d", c), vt[7].exp);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        chk("bp_release_ovalid", 32'(out_valid), 32'd0);
        chk("bp_release_iready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        chk("bp_second_accepted", 32'(in_ready), 32'd0);
        wait_out(lat);
        chk("bp_second_latency", 32'(lat), 32'd8);
        check_lanes("bp_second", vt[6].exp);
        handshake("bp_second");

        // Reset at k=4 during MAC.
        send(0);
        repeat (4) @(posedge clk);
        #1;
        chk("rmac_busy_iready", 32'(in_ready), 32'd0);
        #1 reset_n = 1'b0;
        #1;
        chk("rmac_ovalid", 32'(out_valid), 32'd0);
        chk("rmac_iready", 32'(in_ready), 32'd1);
        check_lanes("rmac", '0);
        @(negedge clk);
        reset_n = 1'b1;
        run(1);

        // Reset while holding a result in DONE.
        send(2);
        wait_out(lat);
        chk("rdone_ovalid_before", 32'(out_valid), 32'd1);
        #1 reset_n = 1'b0;
        #1;
        chk("rdone_ovalid", 32'(out_valid), 32'd0);
        chk("rdone_iready", 32'(in_ready), 32'd1);
        check_lanes("rdone", '0);
        @(negedge clk);
        reset_n = 1'b1;
        run(8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
